// File: rtl/fpadd_arbiter.sv
// fpadd_arbiter: two-requester front end for a shared, fixed-latency FP32 adder.
// The adder takes its operands from add_a/add_b and returns the sum on
// add_result ADD_LAT edges after the operands load. Each response goes back to
// the requester that issued it, and responses come back in issue order.
// Build option: define FPADD_ARB_RR_EN for round-robin arbitration. When it is
// not defined, arbitration is fixed priority and req0 always wins.
module fpadd_arbiter #(
  parameter int ADD_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        resp0_valid,
  output logic [31:0] resp0_data,
  output logic        resp1_valid,
  output logic [31:0] resp1_data,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_result,
  input  logic        drain,
  output logic        drained,
  output logic [2:0]  inflight
);
  // The tag pipe has ADD_LAT+1 stages, [STAGES:0]. A tag leaves the top stage
  // on the edge where add_result holds that tag's sum.
  localparam int STAGES = ADD_LAT;

  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

  state_t            r_state, w_state_nxt;
  logic [STAGES:0]   r_vld_pipe;
  logic [STAGES:0]   r_id_pipe;
  logic [2:0]        r_inflight;
  logic              r_resp0_valid, r_resp1_valid;
  logic [31:0]       r_resp0_data, r_resp1_data;
  logic [31:0]       r_add_a, r_add_b;
  logic              w_pick1;
  logic              w_gnt0, w_gnt1, w_xfer;
  logic              w_resp, w_resp_id;

`ifdef FPADD_ARB_RR_EN
  logic              r_last_gnt;
  // Remember who won the last transfer. Reset to 1 so that req0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_last_gnt <= 1'b1;
    else if (w_xfer) r_last_gnt <= w_gnt1;
  end
  assign w_pick1 = ~r_last_gnt;
`else
  assign w_pick1 = 1'b0;
`endif

  // Combinational grant. w_pick1 only resolves the case where both requesters are valid.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == RUN) begin
      w_gnt0 = req0_valid & ~(req1_valid & w_pick1);
      w_gnt1 = req1_valid & ~(req0_valid & ~w_pick1);
    end
  end

  assign w_xfer    = w_gnt0 | w_gnt1;
  assign w_resp    = r_vld_pipe[STAGES];
  assign w_resp_id = r_id_pipe[STAGES];

  // Tag pipe: each stage holds {valid, requester id} for one issued operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_id_pipe  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:0], w_xfer};
      r_id_pipe  <= {r_id_pipe[STAGES-1:0], w_gnt1};
    end
  end

  // Operand registers. They load only on a transfer and hold their value otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_add_a <= '0;
      r_add_b <= '0;
    end else if (w_xfer) begin
      r_add_a <= w_gnt1 ? req1_a : req0_a;
      r_add_b <= w_gnt1 ? req1_b : req0_b;
    end
  end

  // Capture the sum for the tag that is leaving the pipe. The valid pulse lasts
  // one cycle. The data holds until the next response to the same requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
      r_resp0_data  <= '0;
      r_resp1_data  <= '0;
    end else begin
      r_resp0_valid <= w_resp & ~w_resp_id;
      r_resp1_valid <= w_resp &  w_resp_id;
      if (w_resp && !w_resp_id) r_resp0_data <= add_result;
      if (w_resp &&  w_resp_id) r_resp1_data <= add_result;
    end
  end

  // Count of operations in flight. An issue and a response on the same edge cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight <= '0;
    end else begin
      case ({w_xfer, w_resp})
        2'b10:   r_inflight <= r_inflight + 3'd1;
        2'b01:   r_inflight <= r_inflight - 3'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  // FSM next state. Dropping drain always returns to RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (drain) w_state_nxt = DRAIN;
      DRAIN:   if (!drain) w_state_nxt = RUN;
               else if (r_inflight == 3'd0) w_state_nxt = DRAINED;
      DRAINED: if (!drain) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  assign req0_ready  = w_gnt0;
  assign req1_ready  = w_gnt1;
  assign resp0_valid = r_resp0_valid;
  assign resp1_valid = r_resp1_valid;
  assign resp0_data  = r_resp0_data;
  assign resp1_data  = r_resp1_data;
  assign add_a       = r_add_a;
  assign add_b       = r_add_b;
  assign drained     = (r_state == DRAINED);
  assign inflight    = r_inflight;
endmodule

// File: tb/tb_fpadd_arbiter.sv
// tb_fpadd_arbiter: directed and random stimulus for fpadd_arbiter. A
// transaction-level model predicts the results: a queue of pending operations
// with due cycles, the arbitration rule and the drain state.
module tb_fpadd_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp0_data, resp1_data, add_a, add_b, add_result;
  logic        drain, drained;
  logic [2:0]  inflight;

  fpadd_arbiter #(.ADD_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data),
    .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .drain(drain), .drained(drained), .inflight(inflight)
  );

  always #5 clk = ~clk;

  // Stand-in adder. Equal normal operands give the exact doubled value
  // (exponent + 1). Any other pair gives a distinct mixed value.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a == b && a[30:23] != 8'h00 && a[30:23] < 8'hFE) return a + 32'h0080_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h1234_5678;
  endfunction

  // The adder pipeline is LAT edges deep, measured from the operand registers.
  logic [31:0] apipe [1:LAT];
  always @(posedge clk) begin
    apipe[1] <= fadd(add_a, add_b);
    for (int k = 2; k <= LAT; k++) apipe[k] <= apipe[k-1];
  end
  assign add_result = apipe[LAT];

  // Reference model.
  typedef struct { int id; logic [31:0] sum; int due; } op_t;
  typedef enum { M_RUN, M_DRAIN, M_DRAINED } mst_t;
  op_t         q[$];
  mst_t        mst;
  int          cyc, last_gnt;
  logic [31:0] exp_d0, exp_d1, exp_aa, exp_ab;
  int          checks = 0, errors = 0;

  // Requester-side stimulus. Operands are held until they are granted.
  logic        v0, v1, dr;
  logic [31:0] p0a, p0b, p1a, p1b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    mst = M_RUN; last_gnt = 1;
    exp_d0 = '0; exp_d1 = '0; exp_aa = '0; exp_ab = '0;
  endtask

  // One clock cycle. Drive the inputs at the negedge, check ready before the
  // posedge, advance the model at the posedge, then check the registered outputs.
  task automatic step();
    logic e0, e1, x0, x1;
    op_t  op;
    req0_valid = v0; req0_a = p0a; req0_b = p0b;
    req1_valid = v1; req1_a = p1a; req1_b = p1b;
    drain = dr;
    #1;
    e0 = 1'b0; e1 = 1'b0;
    if (mst == M_RUN) begin
      if (v0 && v1) begin
`ifdef FPADD_ARB_RR_EN
        if (last_gnt == 0) e1 = 1'b1; else e0 = 1'b1;
`else
        e0 = 1'b1;
`endif
      end else begin
        e0 = v0; e1 = v1;
      end
    end
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
    @(posedge clk);
    cyc++;
    case (mst)
      M_RUN:     if (dr) mst = M_DRAIN;
      M_DRAIN:   if (!dr) mst = M_RUN; else if (q.size() == 0) mst = M_DRAINED;
      M_DRAINED: if (!dr) mst = M_RUN;
      default:   mst = M_RUN;
    endcase
    x0 = 1'b0; x1 = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      op = q.pop_front();
      if (op.id == 0) begin x0 = 1'b1; exp_d0 = op.sum; end
      else            begin x1 = 1'b1; exp_d1 = op.sum; end
    end
    if (e0) begin
      q.push_back('{0, fadd(p0a, p0b), cyc + LAT + 1});
      exp_aa = p0a; exp_ab = p0b; last_gnt = 0;
      v0 = 1'b0; p0a = $urandom; p0b = $urandom;
    end
    if (e1) begin
      q.push_back('{1, fadd(p1a, p1b), cyc + LAT + 1});
      exp_aa = p1a; exp_ab = p1b; last_gnt = 1;
      v1 = 1'b0; p1a = $urandom; p1b = $urandom;
    end
    #1;
    chk("resp0_valid", {31'd0, resp0_valid}, {31'd0, x0});
    chk("resp1_valid", {31'd0, resp1_valid}, {31'd0, x1});
    chk("resp0_data", resp0_data, exp_d0);
    chk("resp1_data", resp1_data, exp_d1);
    chk("inflight", {29'd0, inflight}, q.size());
    chk("drained", {31'd0, drained}, {31'd0, mst == M_DRAINED});
    chk("add_a", add_a, exp_aa);
    chk("add_b", add_b, exp_ab);
    @(negedge clk);
  endtask

  // Assert reset between clock edges. The reset is asynchronous, so the
  // outputs must already be clear before the next edge.
  task automatic reset_dut();
    reset = 1'b1;
    v0 = 1'b0; v1 = 1'b0; dr = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; drain = 1'b0;
    #1;
    model_clear();
    chk("rst_resp0_valid", {31'd0, resp0_valid}, 32'd0);
    chk("rst_resp1_valid", {31'd0, resp1_valid}, 32'd0);
    chk("rst_inflight", {29'd0, inflight}, 32'd0);
    repeat (LAT + 1) begin
      @(posedge clk); #1;
      chk("rst_resp0_valid_hold", {31'd0, resp0_valid}, 32'd0);
      chk("rst_resp1_valid_hold", {31'd0, resp1_valid}, 32'd0);
    end
    chk("rst_drained", {31'd0, drained}, 32'd0);
    chk("rst_resp0_data", resp0_data, 32'd0);
    chk("rst_resp1_data", resp1_data, 32'd0);
    chk("rst_add_a", add_a, 32'd0);
    chk("rst_add_b", add_b, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    cyc = 0;
    p0a = $urandom; p0b = $urandom; p1a = $urandom; p1b = $urandom;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    @(negedge clk);
    reset_dut();

    // 1.0 + 1.0 from req0. Inflight reads 1,1,1,0 and resp0 returns 0x40000000.
    v0 = 1'b1; p0a = 32'h3F80_0000; p0b = 32'h3F80_0000;
    step();
    repeat (4) step();

    // Both requesters valid for 4 cycles, starting from the reset pointer.
    reset_dut();
    repeat (4) begin v0 = 1'b1; v1 = 1'b1; step(); end
    repeat (LAT + 3) step();

    // An issue and a response on the same edge. Inflight stays at 1.
    v0 = 1'b1; step();
    repeat (LAT) step();
    v1 = 1'b1; step();
    repeat (LAT + 2) step();

    // 3 back-to-back issues, then drain. The ready check on a held request stays 0.
    repeat (3) begin v0 = 1'b1; step(); end
    dr = 1'b1; step();
    v0 = 1'b1;
    repeat (7) step();
    dr = 1'b0; step();
    step();
    repeat (LAT + 2) step();

    // Random traffic with occasional drain toggles.
    for (int i = 0; i < 300; i++) begin
      if (!v0) v0 = 1'($urandom_range(0, 1));
      if (!v1) v1 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) dr = ~dr;
      step();
    end
    v0 = 1'b0; v1 = 1'b0; dr = 1'b0;
    repeat (LAT + 3) step();

    // Reset with 2 operations in flight: no pulse, then a clean transfer after reset.
    v0 = 1'b1; step();
    v1 = 1'b1; step();
    reset_dut();
    repeat (LAT + 2) step();
    v0 = 1'b1; p0a = 32'h4000_0000; p0b = 32'h4000_0000;
    step();
    repeat (LAT + 2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
